// File: rtl/mips_pkg.sv
// Shared MIPS control definitions: opcodes, Funct codes, ALU encodings, FSM states.
// The JUMP state exists only when MULTICYCLE_JUMP_EN is defined.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALU operation class chosen by the controller; aludec resolves it to ALUControl
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_e;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXECUTE,
        ALUWB,
        BRANCH,
        ADDIEX,
`ifdef MULTICYCLE_JUMP_EN
        ADDIWB,
        JUMP
`else
        ADDIWB
`endif
    } state_e;

endpackage

// File: rtl/aludec.sv
// ALU decoder: maps ALU-op class plus Funct to the 3-bit ALUControl code.
// Latency: purely combinational.
// Backpressure: none; output follows inputs every cycle.
module aludec
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    input  aluop_e     alu_op,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_control = ALU_ADD;
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_SLT:  alu_control = ALU_SLT;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM (lw, sw, R-type, beq, addi; j with MULTICYCLE_JUMP_EN).
// Latency: outputs combinational from state and inputs; lw 5, sw/R/addi 4, beq/j 3 cycles.
// Backpressure: FETCH, MEMRD and MEMWR hold until MemReady; synchronous active-low RST.
module multicycle_controller
    import mips_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] OP,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       IorD,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegDst,
    output logic       Mem2Reg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUControl,
    output logic       PCEn
);

    state_e state;
    aluop_e alu_op;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:   if (MemReady) state <= DECODE;
                DECODE: begin
                    case (OP)
                        OP_LW, OP_SW: state <= MEMADR;
                        OP_RTYPE:     state <= EXECUTE;
                        OP_BEQ:       state <= BRANCH;
                        OP_ADDI:      state <= ADDIEX;
`ifdef MULTICYCLE_JUMP_EN
                        OP_J:         state <= JUMP;
`endif
                        default:      state <= FETCH;
                    endcase
                end
                MEMADR:  state <= (OP == OP_SW) ? MEMWR : MEMRD;
                MEMRD:   if (MemReady) state <= MEMWB;
                MEMWR:   if (MemReady) state <= FETCH;
                EXECUTE: state <= ALUWB;
                ADDIEX:  state <= ADDIWB;
                default: state <= FETCH;
            endcase
        end
    end

    always_comb begin
        IorD     = 1'b0;
        IRWrite  = 1'b0;
        MemWrite = 1'b0;
        RegDst   = 1'b0;
        Mem2Reg  = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        PCSrc    = 2'b00;
        PCEn     = 1'b0;
        alu_op   = ALUOP_ADD;
        // In reset, present FETCH datapath steering with every write enable held off
        if (!RST) begin
            ALUSrcB = 2'b01;
        end else begin
            case (state)
                FETCH: begin
                    ALUSrcB = 2'b01;
                    IRWrite = MemReady;
                    PCEn    = MemReady;
                end
                DECODE:  ALUSrcB = 2'b11;
                MEMADR, ADDIEX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                MEMRD:   IorD = 1'b1;
                MEMWR: begin
                    IorD     = 1'b1;
                    MemWrite = MemReady;
                end
                MEMWB: begin
                    Mem2Reg  = 1'b1;
                    RegWrite = 1'b1;
                end
                EXECUTE: begin
                    ALUSrcA = 1'b1;
                    alu_op  = ALUOP_FUNCT;
                end
                ALUWB: begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                end
                ADDIWB:  RegWrite = 1'b1;
                BRANCH: begin
                    ALUSrcA = 1'b1;
                    alu_op  = ALUOP_SUB;
                    PCSrc   = 2'b01;
                    PCEn    = Zero;
                end
`ifdef MULTICYCLE_JUMP_EN
                JUMP: begin
                    PCSrc = 2'b10;
                    PCEn  = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    aludec u_aludec (
        .funct       (Funct),
        .alu_op      (alu_op),
        .alu_control (ALUControl)
    );

endmodule
